osd_event_trigger: RTL and testbench

Watches the packed user-settings word driven from the core/APF side. Once a change has held still for a settle interval, it reports each changed field to the OSD text writer over a valid/ready handshake. After the last field is accepted, it pulses the enable input of the OSD display timer. It is the producer end of the OSD timer's `enable` line: the trigger decides when to show, and the timer decides for how long.

---
 rtl/osd_pkg.sv | 17 +
 rtl/osd_field_pick.sv | 20 ++
 rtl/osd_event_trigger.sv | 175 +++++++++++++++++
 tb/tb_osd_event_trigger.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/osd_pkg.sv
// Shared types and timing helpers for the OSD trigger and display-timer blocks.
package osd_pkg;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        SETTLE = 3'd2,
        REQ    = 3'd3,
        FIRE   = 3'd4
    } osd_trig_state_t;

    // Number of clock cycles spanning `ms` milliseconds at `clk_hz`.
    function automatic int unsigned OSD_MS_CYCLES(input int unsigned clk_hz, input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage

// File: rtl/osd_field_pick.sv
// Lowest-set-bit priority encoder used to choose the next field to report.
module osd_field_pick #(
    parameter int unsigned N     = 32'd4,
    parameter int unsigned IDX_W = (N > 32'd1) ? $clog2(N) : 32'd1
) (
    input  logic [N-1:0]     pend,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the one left in idx.
    always_comb begin
        idx = {IDX_W{1'b0}};
        any = |pend;
        for (int i = N - 1; i >= 0; i--) begin
            idx = pend[i] ? IDX_W'(i) : idx;
        end
    end

endmodule

// File: rtl/osd_event_trigger.sv
// Reports settled settings-word field changes to the OSD text writer, then
// pulses the OSD display timer's enable once all changed fields are accepted.
module osd_event_trigger
    import osd_pkg::*;
#(
    parameter  int unsigned CLK_HZ     = 32'd32_000_000,
    parameter  int unsigned SETTLE_MS  = 32'd50,
    parameter  int unsigned CFG_W      = 32'd16,
    parameter  int unsigned NUM_FIELDS = 32'd4,
    localparam int unsigned FIELD_W    = CFG_W / NUM_FIELDS,
    localparam int unsigned IDX_W      = (NUM_FIELDS > 32'd1) ? $clog2(NUM_FIELDS) : 32'd1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [CFG_W-1:0]   cfg_in,
    output logic               msg_valid,
    output logic [IDX_W-1:0]   msg_field,
    output logic [FIELD_W-1:0] msg_value,
    input  logic               msg_ready,
    output logic               osd_enable,
    output logic               busy
);

    localparam int unsigned SETTLE_CYCLES = OSD_MS_CYCLES(CLK_HZ, SETTLE_MS);
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 32'd0) ? $clog2(SETTLE_CYCLES + 32'd1) : 32'd1;
    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);
    localparam logic [NUM_FIELDS-1:0] FIELD_LSB = NUM_FIELDS'(32'd1);

    if (SETTLE_CYCLES == 32'd0) begin : g_settle_zero
        $error("osd_event_trigger: settle interval is zero clock cycles");
    end
    if ((CFG_W % NUM_FIELDS) != 32'd0) begin : g_cfg_split
        $error("osd_event_trigger: CFG_W is not a multiple of NUM_FIELDS");
    end

    osd_trig_state_t       state_r;
    logic [CFG_W-1:0]      ref_r;
    logic [CFG_W-1:0]      cand_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [NUM_FIELDS-1:0] pend_r;
    logic                  msg_valid_r;
    logic [IDX_W-1:0]      msg_field_r;
    logic [FIELD_W-1:0]    msg_value_r;
    logic                  osd_enable_r;
    logic                  busy_r;

    logic [NUM_FIELDS-1:0] diff_mask_s;
    logic [NUM_FIELDS-1:0] pick_src_s;
    logic [IDX_W-1:0]      pick_idx_s;
    logic                  pick_any_s;
    logic [FIELD_W-1:0]    pick_val_s;

    // Per-field mismatch between the candidate and the last reported word.
    always_comb begin
        diff_mask_s = {NUM_FIELDS{1'b0}};
        for (int i = 0; i < NUM_FIELDS; i++) begin
            diff_mask_s[i] = (cand_r[i*FIELD_W +: FIELD_W] != ref_r[i*FIELD_W +: FIELD_W]);
        end
    end

    // Fields still owed after this edge: the fresh mask leaving SETTLE, or
    // the pending mask minus the field being accepted while in REQ.
    always_comb begin
        pick_src_s = {NUM_FIELDS{1'b0}};
        case (state_r)
            SETTLE:  pick_src_s = diff_mask_s;
            REQ:     pick_src_s = pend_r & ~(FIELD_LSB << msg_field_r);
            default: pick_src_s = {NUM_FIELDS{1'b0}};
        endcase
    end

    osd_field_pick #(
        .N     (NUM_FIELDS),
        .IDX_W (IDX_W)
    ) u_pick (
        .pend (pick_src_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Candidate value of the field chosen by the encoder.
    always_comb begin
        pick_val_s = {FIELD_W{1'b0}};
        for (int i = 0; i < NUM_FIELDS; i++) begin
            pick_val_s = (pick_idx_s == IDX_W'(i)) ? cand_r[i*FIELD_W +: FIELD_W] : pick_val_s;
        end
    end

    // Trigger state machine with registered handshake and pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= INIT;
            ref_r        <= {CFG_W{1'b0}};
            cand_r       <= {CFG_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            pend_r       <= {NUM_FIELDS{1'b0}};
            msg_valid_r  <= 1'b0;
            msg_field_r  <= {IDX_W{1'b0}};
            msg_value_r  <= {FIELD_W{1'b0}};
            osd_enable_r <= 1'b0;
            busy_r       <= 1'b1;
        end else begin
            osd_enable_r <= 1'b0;
            case (state_r)
                INIT: begin
                    ref_r   <= cfg_in;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                IDLE: begin
                    if (cfg_in != ref_r) begin
                        cand_r  <= cfg_in;
                        cnt_r   <= SETTLE_RELOAD;
                        state_r <= SETTLE;
                        busy_r  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cfg_in != cand_r) begin
                        cand_r <= cfg_in;
                        cnt_r  <= SETTLE_RELOAD;
                    end else if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (!pick_any_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        pend_r      <= diff_mask_s;
                        msg_valid_r <= 1'b1;
                        msg_field_r <= pick_idx_s;
                        msg_value_r <= pick_val_s;
                        state_r     <= REQ;
                    end
                end
                REQ: begin
                    if (msg_valid_r && msg_ready) begin
                        // msg_value_r mirrors the candidate field, as cand_r is frozen here.
                        for (int i = 0; i < NUM_FIELDS; i++) begin
                            if (msg_field_r == IDX_W'(i)) begin
                                ref_r[i*FIELD_W +: FIELD_W] <= msg_value_r;
                            end
                        end
                        pend_r <= pick_src_s;
                        if (pick_any_s) begin
                            msg_field_r <= pick_idx_s;
                            msg_value_r <= pick_val_s;
                        end else begin
                            msg_valid_r <= 1'b0;
                            state_r     <= FIRE;
                        end
                    end
                end
                FIRE: begin
                    osd_enable_r <= 1'b1;
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r     <= INIT;
                    msg_valid_r <= 1'b0;
                    pend_r      <= {NUM_FIELDS{1'b0}};
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    assign msg_valid  = msg_valid_r;
    assign msg_field  = msg_field_r;
    assign msg_value  = msg_value_r;
    assign osd_enable = osd_enable_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_osd_event_trigger.sv
// Self-checking bench for osd_event_trigger: directed scenarios plus random
// stimulus compared against a queue-based behavioural model.
module tb_osd_event_trigger;

    localparam int unsigned CLK_HZ     = 32'd1000;
    localparam int unsigned SETTLE_MS  = 32'd4;
    localparam int unsigned CFG_W      = 32'd16;
    localparam int unsigned NUM_FIELDS = 32'd4;
    localparam int          SETTLE_CYC = 1000 / 1000 * 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cfg_in = 16'h0000;
    logic        msg_ready = 1'b0;
    logic        msg_valid;
    logic [1:0]  msg_field;
    logic [3:0]  msg_value;
    logic        osd_enable;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;
    int report_cnt = 0;
    int p0, r0;

    // Behavioural model: reports queued as {field, value}, lowest field first.
    logic [15:0] m_ref, m_cand;
    int          m_left;
    bit          m_starting, m_watching, m_fire_pending;
    logic [5:0]  rep_q[$];
    bit          exp_valid, exp_enable, exp_busy;
    logic [1:0]  exp_field;
    logic [3:0]  exp_value;

    osd_event_trigger #(
        .CLK_HZ     (CLK_HZ),
        .SETTLE_MS  (SETTLE_MS),
        .CFG_W      (CFG_W),
        .NUM_FIELDS (NUM_FIELDS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_in     (cfg_in),
        .msg_valid  (msg_valid),
        .msg_field  (msg_field),
        .msg_value  (msg_value),
        .msg_ready  (msg_ready),
        .osd_enable (osd_enable),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic refresh();
        exp_valid = (rep_q.size() > 0);
        exp_field = exp_valid ? rep_q[0][5:4] : 2'd0;
        exp_value = exp_valid ? rep_q[0][3:0] : 4'd0;
        exp_busy  = m_starting || m_watching || exp_valid || m_fire_pending;
    endtask

    task automatic model_reset();
        rep_q.delete();
        m_starting     = 1'b1;
        m_watching     = 1'b0;
        m_fire_pending = 1'b0;
        m_ref          = 16'h0000;
        m_cand         = 16'h0000;
        m_left         = 0;
        exp_enable     = 1'b0;
        refresh();
    endtask

    // Effect of one rising edge with the given inputs.
    task automatic model_edge(input logic [15:0] cfg, input logic rdy);
        logic [5:0] h;
        exp_enable = 1'b0;
        if (m_starting) begin
            m_ref      = cfg;
            m_starting = 1'b0;
        end else if (m_fire_pending) begin
            m_fire_pending = 1'b0;
            exp_enable     = 1'b1;
        end else if (rep_q.size() > 0) begin
            if (rdy) begin
                h = rep_q.pop_front();
                m_ref[h[5:4]*4 +: 4] = h[3:0];
                if (rep_q.size() == 0) m_fire_pending = 1'b1;
            end
        end else if (m_watching) begin
            if (cfg != m_cand) begin
                m_cand = cfg;
                m_left = SETTLE_CYC - 1;
            end else if (m_left > 0) begin
                m_left--;
            end else begin
                m_watching = 1'b0;
                for (int f = 0; f < 4; f++) begin
                    if (m_cand[f*4 +: 4] != m_ref[f*4 +: 4]) rep_q.push_back({2'(f), m_cand[f*4 +: 4]});
                end
            end
        end else if (cfg != m_ref) begin
            m_watching = 1'b1;
            m_cand     = cfg;
            m_left     = SETTLE_CYC - 1;
        end
        refresh();
    endtask

    task automatic compare_all();
        check_eq("valid", 32'(msg_valid), 32'(exp_valid));
        check_eq("enable", 32'(osd_enable), 32'(exp_enable));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        if (exp_valid) begin
            check_eq("field", 32'(msg_field), 32'(exp_field));
            check_eq("value", 32'(msg_value), 32'(exp_value));
        end
        if (osd_enable === 1'b1) pulse_cnt++;
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic cycle(input logic [15:0] cfg, input logic rdy);
        cfg_in    = cfg;
        msg_ready = rdy;
        if (msg_valid && rdy) report_cnt++;
        @(posedge clk);
        model_edge(cfg, rdy);
        @(negedge clk);
        compare_all();
    endtask

    // Reset asserted between edges so its effect is seen without a clock.
    task automatic do_reset(input logic [15:0] cfg);
        @(negedge clk);
        #2;
        reset_n   = 1'b0;
        cfg_in    = cfg;
        msg_ready = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_field", 32'(msg_field), 32'd0);
        check_eq("rst_value", 32'(msg_value), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        int unsigned r;
        model_reset();

        // Power-up: no message, busy clears once ref is captured.
        do_reset(16'h1234);
        p0 = pulse_cnt; r0 = report_cnt;
        cycle(16'h1234, 1'b0);
        check_eq("s1_busy", 32'(busy), 32'd0);
        repeat (19) cycle(16'h1234, 1'b0);
        check_eq("s1_pulses", 32'(pulse_cnt - p0), 32'd0);
        check_eq("s1_reports", 32'(report_cnt - r0), 32'd0);

        // Single field change with ready held high.
        do_reset(16'h1234);
        cycle(16'h1234, 1'b1);
        p0 = pulse_cnt; r0 = report_cnt;
        repeat (4) cycle(16'h1274, 1'b1);
        check_eq("s2_early", 32'(msg_valid), 32'd0);
        cycle(16'h1274, 1'b1);
        check_eq("s2_valid", 32'(msg_valid), 32'd1);
        check_eq("s2_field", 32'(msg_field), 32'd1);
        check_eq("s2_value", 32'(msg_value), 32'h7);
        cycle(16'h1274, 1'b1);
        check_eq("s2_drop", 32'(msg_valid), 32'd0);
        cycle(16'h1274, 1'b1);
        check_eq("s2_pulse", 32'(osd_enable), 32'd1);
        repeat (5) cycle(16'h1274, 1'b1);
        check_eq("s2_pulses", 32'(pulse_cnt - p0), 32'd1);
        check_eq("s2_reports", 32'(report_cnt - r0), 32'd1);

        // Two fields, back-pressure on the first.
        do_reset(16'h1234);
        cycle(16'h1234, 1'b0);
        p0 = pulse_cnt; r0 = report_cnt;
        repeat (5) cycle(16'hA23F, 1'b0);
        check_eq("s3_f0", 32'(msg_field), 32'd0);
        check_eq("s3_v0", 32'(msg_value), 32'hF);
        repeat (3) cycle(16'hA23F, 1'b0);
        check_eq("s3_hold_valid", 32'(msg_valid), 32'd1);
        check_eq("s3_hold_f0", 32'(msg_field), 32'd0);
        cycle(16'hA23F, 1'b1);
        check_eq("s3_f3", 32'(msg_field), 32'd3);
        check_eq("s3_v3", 32'(msg_value), 32'hA);
        cycle(16'hA23F, 1'b1);
        check_eq("s3_drop", 32'(msg_valid), 32'd0);
        cycle(16'hA23F, 1'b1);
        check_eq("s3_pulse", 32'(osd_enable), 32'd1);
        repeat (4) cycle(16'hA23F, 1'b1);
        check_eq("s3_pulses", 32'(pulse_cnt - p0), 32'd1);
        check_eq("s3_reports", 32'(report_cnt - r0), 32'd2);

        // Reverted glitch is silent.
        do_reset(16'h1234);
        cycle(16'h1234, 1'b1);
        p0 = pulse_cnt; r0 = report_cnt;
        cycle(16'h1235, 1'b1);
        repeat (14) cycle(16'h1234, 1'b1);
        check_eq("s4_pulses", 32'(pulse_cnt - p0), 32'd0);
        check_eq("s4_reports", 32'(report_cnt - r0), 32'd0);
        check_eq("s4_busy", 32'(busy), 32'd0);

        // Changes every 3 cycles never settle; only the final value reports.
        do_reset(16'h1234);
        cycle(16'h1234, 1'b1);
        p0 = pulse_cnt; r0 = report_cnt;
        v = 16'h1234;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) v = v ^ (16'($urandom) | 16'h0001);
            if (v == 16'h5555) v = 16'h5554;
            cycle(v, 1'b1);
        end
        check_eq("s5_quiet", 32'(report_cnt - r0), 32'd0);
        repeat (4) cycle(16'h5555, 1'b1);
        check_eq("s5_early", 32'(msg_valid), 32'd0);
        cycle(16'h5555, 1'b1);
        check_eq("s5_start", 32'(msg_valid), 32'd1);
        repeat (18) cycle(16'h5555, 1'b1);
        check_eq("s5_pulses", 32'(pulse_cnt - p0), 32'd1);
        check_eq("s5_reports", 32'(report_cnt - r0), 32'd4);

        // Reset while a report is pending; ref is recaptured afterwards.
        do_reset(16'h1234);
        cycle(16'h1234, 1'b0);
        repeat (5) cycle(16'h1634, 1'b0);
        check_eq("s6_field", 32'(msg_field), 32'd2);
        check_eq("s6_value", 32'(msg_value), 32'h6);
        do_reset(16'h1634);
        check_eq("s6_async_valid", 32'(msg_valid), 32'd0);
        p0 = pulse_cnt; r0 = report_cnt;
        repeat (15) cycle(16'h1634, 1'b1);
        check_eq("s6_pulses", 32'(pulse_cnt - p0), 32'd0);
        check_eq("s6_reports", 32'(report_cnt - r0), 32'd0);

        // Random stimulus against the model.
        do_reset(16'($urandom));
        v = cfg_in;
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 8) v[$urandom_range(0, 3)*4 +: 4] = 4'($urandom);
            else if (r < 10) v = 16'($urandom);
            cycle(v, 1'($urandom_range(0, 1)));
            if (n == 1500) do_reset(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
